rsa_selftest_ctrl: RTL and testbench
====================================

RSA_SELFTEST_CTRL -- requirements
Module: rsa_selftest_ctrl

Interface
REQ-001 Parameter WORD_WIDTH, default 32: width of message, e, d and N words; seed is WORD_WIDTH/2.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: maximum cycles spent waiting for one RSA core operation.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 go  input  1  one-cycle request to run keygen, then encrypt, then decrypt, then check.
REQ-006 seed_i  input  WORD_WIDTH/2  keygen seed, sampled on accepted go.
REQ-007 plaintext_i  input  WORD_WIDTH  test message, sampled on accepted go.
REQ-008 core_start  output  1  start pulse to the RSA core.
REQ-009 core_mode  output  2  00 idle, 01 keygen, 10 encrypt, 11 decrypt.
REQ-010 core_seed, core_message, core_e, core_d, core_N  output  WORD_WIDTH/2, WORD_WIDTH x4  core operands.
REQ-011 core_done  input  1  core completion, level or pulse.
REQ-012 core_message_o, core_e_o, core_d_o, core_N_o  input  WORD_WIDTH each  core results.
REQ-013 busy  output  1  high from go acceptance until the done pulse.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 pass, fail  output  1 each  result flags, held until the next accepted go.
REQ-016 err_code  output  2  00 none, 01 timeout, 10 plaintext>=N, 11 round-trip mismatch.
REQ-017 e_o, d_o, N_o, cipher_o  output  WORD_WIDTH each  captured key and ciphertext, held until the next accepted go.

Function
REQ-018 FSM states SHALL be IDLE, KG_START, KG_WAIT, ENC_START, ENC_WAIT, DEC_START, DEC_WAIT, CHECK, FINISH.
REQ-019 In IDLE, go=1 SHALL be accepted: capture seed_i and plaintext_i, clear pass/fail/err_code, set busy, go to KG_START.
REQ-020 go while busy SHALL be ignored.
REQ-021 Each *_START state SHALL assert core_start for exactly one cycle and then move to the matching *_WAIT state.
REQ-022 Cycle latency: go sampled at edge k gives core_start=1 in cycle k+1.
REQ-023 core_mode SHALL be valid in *_START and held stable through the matching *_WAIT; it SHALL be 00 in all other states.
REQ-024 Operands: keygen drives core_seed.
REQ-025 Operands: encrypt drives core_message=plaintext, core_e=e_o, core_N=N_o.
REQ-026 Operands: decrypt drives core_message=cipher_o, core_d=d_o, core_N=N_o.
REQ-027 Unused operand outputs SHALL be 0.
REQ-028 Stale-done guard: on entering a *_WAIT state, a done_low_seen flag SHALL be cleared.
REQ-029 The done_low_seen flag SHALL be set in any WAIT cycle with core_done=0.
REQ-030 core_done SHALL be accepted only while done_low_seen=1.
REQ-031 On an accepted core_done in KG_WAIT: capture e_o, d_o, N_o.
REQ-032 After keygen capture, if plaintext>=N_o go to FINISH with fail=1, err_code=10, and issue no encrypt start; otherwise go to ENC_START.
REQ-033 On an accepted core_done in ENC_WAIT: capture cipher_o and go to DEC_START.
REQ-034 On an accepted core_done in DEC_WAIT: register core_message_o and go to CHECK.
REQ-035 CHECK SHALL set pass=1 if the registered result equals plaintext; otherwise set fail=1 and err_code=11.
REQ-036 A per-wait cycle counter SHALL reset on entry to each *_WAIT state.
REQ-037 When the counter reaches TIMEOUT_CYCLES without an accepted done: go to FINISH with fail=1, err_code=01.
REQ-038 If an accepted done and the timeout occur in the same cycle, the done SHALL win.
REQ-039 FINISH SHALL pulse done for one cycle, clear busy, and return to IDLE.
REQ-040 go arriving in the FINISH cycle SHALL be ignored.
REQ-041 pass and fail SHALL never be 1 simultaneously.

Reset
REQ-042 While rst=0, all outputs, captured registers and counters SHALL be 0 and the FSM SHALL be in IDLE, independent of clk.
REQ-043 Reset asserted mid-operation SHALL abort the run without a done pulse.
REQ-044 The first go after reset release SHALL start a normal run.

Verification
REQ-045 Nominal: seed=16'h11AF, plaintext=2, behavioural core -> core_start pulses with modes 01, 10, 11 in order; done pulse; pass=1; err_code=00; decrypted value equals 2.
REQ-046 Timeout: TIMEOUT_CYCLES=16, core never asserts done -> fail=1 and err_code=01 exactly 16 cycles after entering KG_WAIT; no mode 10 start.
REQ-047 Range: core returns N=33, plaintext=32'hFFFFFFFF -> fail=1, err_code=10, only one core_start issued.
REQ-048 Mismatch: core model returns plaintext+1 on decrypt -> fail=1, err_code=11, pass=0.
REQ-049 Stale done: core holds core_done=1 across the start pulse -> controller does not advance until done is seen low and then high again.
REQ-050 Reset mid-run: rst=0 during ENC_WAIT -> all outputs 0 at once, no done pulse; go after release completes with pass=1.

Source files
------------

// File: rtl/rsa_selftest_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rsa_selftest_ctrl
// Function : Sequences an RSA core through keygen, encrypt and decrypt, then
//            checks that the round trip reproduces the test message.
// Revision : 1.0 - initial release
// ============================================================================
module rsa_selftest_ctrl #(
    parameter int WORD_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      go,
    input  logic [WORD_WIDTH/2-1:0]   seed_i,
    input  logic [WORD_WIDTH-1:0]     plaintext_i,
    output logic                      core_start,
    output logic [1:0]                core_mode,
    output logic [WORD_WIDTH/2-1:0]   core_seed,
    output logic [WORD_WIDTH-1:0]     core_message,
    output logic [WORD_WIDTH-1:0]     core_e,
    output logic [WORD_WIDTH-1:0]     core_d,
    output logic [WORD_WIDTH-1:0]     core_N,
    input  logic                      core_done,
    input  logic [WORD_WIDTH-1:0]     core_message_o,
    input  logic [WORD_WIDTH-1:0]     core_e_o,
    input  logic [WORD_WIDTH-1:0]     core_d_o,
    input  logic [WORD_WIDTH-1:0]     core_N_o,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      fail,
    output logic [1:0]                err_code,
    output logic [WORD_WIDTH-1:0]     e_o,
    output logic [WORD_WIDTH-1:0]     d_o,
    output logic [WORD_WIDTH-1:0]     N_o,
    output logic [WORD_WIDTH-1:0]     cipher_o
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        KG_START  = 4'd1,
        KG_WAIT   = 4'd2,
        ENC_START = 4'd3,
        ENC_WAIT  = 4'd4,
        DEC_START = 4'd5,
        DEC_WAIT  = 4'd6,
        CHECK     = 4'd7,
        FINISH    = 4'd8
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [WORD_WIDTH/2-1:0]   r_seed;
    logic [WORD_WIDTH-1:0]     r_plain;
    logic [WORD_WIDTH-1:0]     r_e;
    logic [WORD_WIDTH-1:0]     r_d;
    logic [WORD_WIDTH-1:0]     r_N;
    logic [WORD_WIDTH-1:0]     r_cipher;
    logic [WORD_WIDTH-1:0]     r_dec;
    logic                      r_done_low_seen;
    logic [c_CNT_W-1:0]        r_cnt;
    logic                      r_pass;
    logic                      r_fail;
    logic [1:0]                r_err;
    logic                      w_in_wait;
    logic                      w_accept;
    logic                      w_timeout;
    logic                      w_range_bad;

    assign w_in_wait   = (r_state == KG_WAIT) || (r_state == ENC_WAIT) || (r_state == DEC_WAIT);
    // A done level left over from the previous operation must drop before it counts.
    assign w_accept    = w_in_wait && core_done && r_done_low_seen;
    assign w_timeout   = w_in_wait && (r_cnt == c_CNT_LAST);
    assign w_range_bad = (r_plain >= core_N_o);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        core_start = 1'b0;
        core_mode  = 2'b00;
        case (r_state)
            IDLE:      if (go) w_next = KG_START;
            KG_START:  begin core_start = 1'b1; core_mode = 2'b01; w_next = KG_WAIT; end
            KG_WAIT: begin
                core_mode = 2'b01;
                if (w_accept)       w_next = w_range_bad ? FINISH : ENC_START;
                else if (w_timeout) w_next = FINISH;
            end
            ENC_START: begin core_start = 1'b1; core_mode = 2'b10; w_next = ENC_WAIT; end
            ENC_WAIT: begin
                core_mode = 2'b10;
                if (w_accept)       w_next = DEC_START;
                else if (w_timeout) w_next = FINISH;
            end
            DEC_START: begin core_start = 1'b1; core_mode = 2'b11; w_next = DEC_WAIT; end
            DEC_WAIT: begin
                core_mode = 2'b11;
                if (w_accept)       w_next = CHECK;
                else if (w_timeout) w_next = FINISH;
            end
            CHECK:     w_next = FINISH;
            FINISH:    w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_comb begin
        core_seed    = '0;
        core_message = '0;
        core_e       = '0;
        core_d       = '0;
        core_N       = '0;
        case (r_state)
            KG_START, KG_WAIT:   core_seed = r_seed;
            ENC_START, ENC_WAIT: begin core_message = r_plain;  core_e = r_e; core_N = r_N; end
            DEC_START, DEC_WAIT: begin core_message = r_cipher; core_d = r_d; core_N = r_N; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seed          <= '0;
            r_plain         <= '0;
            r_e             <= '0;
            r_d             <= '0;
            r_N             <= '0;
            r_cipher        <= '0;
            r_dec           <= '0;
            r_done_low_seen <= 1'b0;
            r_cnt           <= '0;
            r_pass          <= 1'b0;
            r_fail          <= 1'b0;
            r_err           <= 2'b00;
        end else begin
            case (r_state)
                IDLE: if (go) begin
                    r_seed  <= seed_i;
                    r_plain <= plaintext_i;
                    r_pass  <= 1'b0;
                    r_fail  <= 1'b0;
                    r_err   <= 2'b00;
                end
                KG_START, ENC_START, DEC_START: begin
                    r_done_low_seen <= 1'b0;
                    r_cnt           <= '0;
                end
                KG_WAIT, ENC_WAIT, DEC_WAIT: begin
                    if (!core_done) r_done_low_seen <= 1'b1;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_accept) begin
                        if (r_state == KG_WAIT) begin
                            r_e <= core_e_o;
                            r_d <= core_d_o;
                            r_N <= core_N_o;
                            if (w_range_bad) begin
                                r_fail <= 1'b1;
                                r_err  <= 2'b10;
                            end
                        end else if (r_state == ENC_WAIT) begin
                            r_cipher <= core_message_o;
                        end else begin
                            r_dec <= core_message_o;
                        end
                    end else if (w_timeout) begin
                        r_fail <= 1'b1;
                        r_err  <= 2'b01;
                    end
                end
                CHECK: begin
                    if (r_dec == r_plain) begin
                        r_pass <= 1'b1;
                    end else begin
                        r_fail <= 1'b1;
                        r_err  <= 2'b11;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == FINISH);
    assign pass     = r_pass;
    assign fail     = r_fail;
    assign err_code = r_err;
    assign e_o      = r_e;
    assign d_o      = r_d;
    assign N_o      = r_N;
    assign cipher_o = r_cipher;

endmodule
`default_nettype wire

// File: tb/tb_rsa_selftest_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsa_selftest_ctrl
// Function : Self-checking bench for rsa_selftest_ctrl with a behavioural core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_selftest_ctrl;

    localparam int W  = 32;
    localparam int HW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          go  = 1'b0;
    logic [HW-1:0] seed_i = '0;
    logic [W-1:0]  plaintext_i = '0;
    logic          core_start;
    logic [1:0]    core_mode;
    logic [HW-1:0] core_seed;
    logic [W-1:0]  core_message, core_e, core_d, core_N;
    logic          core_done;
    logic [W-1:0]  core_message_o, core_e_o, core_d_o, core_N_o;
    logic          busy, done, pass, fail;
    logic [1:0]    err_code;
    logic [W-1:0]  e_o, d_o, N_o, cipher_o;

    always #5 clk = ~clk;

    rsa_selftest_ctrl #(.WORD_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .go(go), .seed_i(seed_i), .plaintext_i(plaintext_i),
        .core_start(core_start), .core_mode(core_mode), .core_seed(core_seed),
        .core_message(core_message), .core_e(core_e), .core_d(core_d), .core_N(core_N),
        .core_done(core_done), .core_message_o(core_message_o), .core_e_o(core_e_o),
        .core_d_o(core_d_o), .core_N_o(core_N_o), .busy(busy), .done(done),
        .pass(pass), .fail(fail), .err_code(err_code), .e_o(e_o), .d_o(d_o),
        .N_o(N_o), .cipher_o(cipher_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Small textbook key pairs selected by the low seed bits.
    task automatic key_for(input logic [HW-1:0] s, output logic [W-1:0] e, output logic [W-1:0] d,
                           output logic [W-1:0] n);
        case (s[1:0])
            2'd0:    begin n = 3233; e = 17; d = 2753; end
            2'd1:    begin n = 33;   e = 3;  d = 7;    end
            2'd2:    begin n = 143;  e = 7;  d = 103;  end
            default: begin n = 3127; e = 3;  d = 2011; end
        endcase
    endtask

    function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                            input logic [W-1:0] n);
        logic [63:0] r, x;
        if (n == 0) return '0;
        r = 64'd1 % 64'(n);
        x = 64'(b) % 64'(n);
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = (r * x) % 64'(n);
            x = (x * x) % 64'(n);
        end
        return W'(r);
    endfunction

    // Outcome of one self-test derived from the rules: timeout, range, round trip.
    task automatic expect_of(input logic [HW-1:0] s, input logic [W-1:0] p, input bit badn,
                             input bit mis, input bit hang, output bit ep, output bit ef,
                             output logic [1:0] ee, output int es);
        logic [W-1:0] e, d, n;
        key_for(s, e, d, n);
        if (badn) n = 33;
        if (hang)        begin ep = 0; ef = 1; ee = 2'b01; es = 1; end
        else if (p >= n) begin ep = 0; ef = 1; ee = 2'b10; es = 1; end
        else if (mis)    begin ep = 0; ef = 1; ee = 2'b11; es = 3; end
        else             begin ep = 1; ef = 0; ee = 2'b00; es = 3; end
    endtask

    // ---------------- behavioural RSA core ----------------
    bit           cfg_hang = 0, cfg_badn = 0, cfg_mis = 0, cfg_stale = 0;
    logic [HW-1:0] cur_seed = '0;
    logic [W-1:0]  cur_pt = '0;
    int            q_modes[$];
    int            m_cnt, m_hold;
    logic [W-1:0]  p_msg, p_e, p_d, p_N, m_e, m_d, m_N, m_c;

    initial begin
        core_done = 0; core_message_o = '0; core_e_o = '0; core_d_o = '0; core_N_o = '0;
        m_cnt = 0; m_hold = 0; p_msg = '0; p_e = '0; p_d = '0; p_N = '0;
        m_e = '0; m_d = '0; m_N = '0; m_c = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                core_done = 0; m_cnt = 0; m_hold = 0;
            end else if (core_start) begin
                q_modes.push_back(int'(core_mode));
                case (core_mode)
                    2'b01: begin
                        chk("kg_seed", 64'(core_seed), 64'(cur_seed));
                        chk("kg_unused", 64'(core_message | core_e | core_d | core_N), 64'd0);
                        key_for(core_seed, p_e, p_d, p_N);
                        if (cfg_badn) p_N = 33;
                        m_e = p_e; m_d = p_d; m_N = p_N; p_msg = '0;
                    end
                    2'b10: begin
                        chk("enc_msg", 64'(core_message), 64'(cur_pt));
                        chk("enc_e", 64'(core_e), 64'(m_e));
                        chk("enc_N", 64'(core_N), 64'(m_N));
                        chk("enc_unused", 64'(core_d) | 64'(core_seed), 64'd0);
                        p_msg = modexp(core_message, core_e, core_N);
                        m_c = p_msg;
                    end
                    2'b11: begin
                        chk("dec_msg", 64'(core_message), 64'(m_c));
                        chk("dec_d", 64'(core_d), 64'(m_d));
                        chk("dec_N", 64'(core_N), 64'(m_N));
                        chk("dec_unused", 64'(core_e) | 64'(core_seed), 64'd0);
                        p_msg = modexp(core_message, core_d, core_N) + (cfg_mis ? 1 : 0);
                    end
                    default: chk("start_mode_valid", 64'(core_mode), 64'd1);
                endcase
                m_cnt = cfg_hang ? 0 : int'($urandom_range(6, 2));
                if (cfg_stale) begin
                    m_hold = 4;
                    core_message_o = '0; core_e_o = '0; core_d_o = '0; core_N_o = '0;
                end else begin
                    core_done = 0;
                end
            end else if (m_hold > 0) begin
                m_hold--;
                if (m_hold == 0) core_done = 0;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    core_message_o = p_msg; core_e_o = p_e; core_d_o = p_d; core_N_o = p_N;
                    core_done = 1;
                end
            end else if (!cfg_stale) begin
                core_done = 0;
            end else if (!busy) begin
                core_done = 1;
            end
        end
    end

    // ---------------- run one self-test ----------------
    int r_done_cnt, r_fail_cyc, r_done_cyc, r_both;

    task automatic run(input logic [HW-1:0] s, input logic [W-1:0] p, input bit inj);
        r_done_cnt = 0; r_fail_cyc = -1; r_done_cyc = -1; r_both = 0;
        cur_seed = s; cur_pt = p;
        repeat (2) @(negedge clk);
        q_modes.delete();
        seed_i = s; plaintext_i = p; go = 1;
        @(posedge clk); #1;
        chk("start_latency", 64'({core_start, core_mode}), 64'(3'b101));
        chk("flags_cleared", 64'({pass, fail, err_code}), 64'd0);
        chk("busy_set", 64'(busy), 64'd1);
        for (int c = 2; c <= 200; c++) begin
            @(negedge clk);
            go = inj && (c == 4);
            @(posedge clk); #1;
            if (fail && r_fail_cyc < 0) r_fail_cyc = c;
            if (pass && fail) r_both++;
            if (done) begin r_done_cnt++; r_done_cyc = c; end
            if (r_done_cnt > 0 && c >= r_done_cyc + 3) break;
        end
        go = 0;
    endtask

    function automatic int enc_modes();
        int v = 0;
        for (int i = q_modes.size() - 1; i >= 0; i--) v = v * 4 + q_modes[i];
        return v;
    endfunction

    task automatic apply(input logic [HW-1:0] s, input logic [W-1:0] p, input bit badn,
                         input bit mis, input bit hang, input bit stale, input bit inj,
                         input bit ep, input bit ef, input logic [1:0] ee, input int es);
        logic [W-1:0] e, d, n;
        cfg_badn = badn; cfg_mis = mis; cfg_hang = hang; cfg_stale = stale;
        run(s, p, inj);
        chk("done_pulses", 64'(r_done_cnt), 64'd1);
        chk("pass", 64'(pass), 64'(ep));
        chk("fail", 64'(fail), 64'(ef));
        chk("err_code", 64'(err_code), 64'(ee));
        chk("busy_after", 64'(busy), 64'd0);
        chk("pass_fail_excl", 64'(r_both), 64'd0);
        chk("mode_seq", 64'(enc_modes()), (es == 3) ? 64'd57 : 64'd1);
        key_for(s, e, d, n);
        if (badn) n = 33;
        if (ep) begin
            chk("e_o", 64'(e_o), 64'(e));
            chk("d_o", 64'(d_o), 64'(d));
            chk("N_o", 64'(N_o), 64'(n));
            chk("cipher_o", 64'(cipher_o), 64'(modexp(p, e, n)));
        end
        if (ee == 2'b10) chk("N_o_range", 64'(N_o), 64'(n));
        if (hang) begin
            chk("timeout_cycle", 64'(r_fail_cyc), 64'd18);
            chk("timeout_done_cycle", 64'(r_done_cyc), 64'd18);
        end
        cfg_badn = 0; cfg_mis = 0; cfg_hang = 0; cfg_stale = 0;
    endtask

    typedef struct {
        logic [HW-1:0] seed;
        logic [W-1:0]  pt;
        bit            badn, mis, hang, stale, inj;
        bit            ep, ef;
        logic [1:0]    ee;
        int            es;
    } vec_t;

    vec_t vt[8];

    function automatic logic all_outs_or();
        return core_start | (|core_mode) | (|core_seed) | (|core_message) | (|core_e) |
               (|core_d) | (|core_N) | busy | done | pass | fail | (|err_code) |
               (|e_o) | (|d_o) | (|N_o) | (|cipher_o);
    endfunction

    initial begin
        bit ep, ef; logic [1:0] ee; int es;
        logic [HW-1:0] s; logic [W-1:0] p, ke, kd, kn;
        bit mis, seen;

        vt[0] = '{16'h11AF, 32'd2,          0, 0, 0, 0, 0, 1, 0, 2'b00, 3};
        vt[1] = '{16'h11AF, 32'd2,          0, 0, 1, 0, 0, 0, 1, 2'b01, 1};
        vt[2] = '{16'h11AF, 32'hFFFFFFFF,   1, 0, 0, 0, 0, 0, 1, 2'b10, 1};
        vt[3] = '{16'h11AF, 32'd2,          0, 1, 0, 0, 0, 0, 1, 2'b11, 3};
        vt[4] = '{16'h11AF, 32'd2,          0, 0, 0, 1, 0, 1, 0, 2'b00, 3};
        vt[5] = '{16'h0000, 32'd3232,       0, 0, 0, 0, 1, 1, 0, 2'b00, 3};
        vt[6] = '{16'h0002, 32'd143,        0, 0, 0, 0, 0, 0, 1, 2'b10, 1};
        vt[7] = '{16'h0001, 32'd0,          0, 0, 0, 0, 1, 1, 0, 2'b00, 3};

        #1;
        chk("reset_outputs_noclk", 64'(all_outs_or()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_clk", 64'(all_outs_or()), 64'd0);
        @(negedge clk); rst = 1;

        for (int i = 0; i < 8; i++)
            apply(vt[i].seed, vt[i].pt, vt[i].badn, vt[i].mis, vt[i].hang, vt[i].stale,
                  vt[i].inj, vt[i].ep, vt[i].ef, vt[i].ee, vt[i].es);

        for (int i = 0; i < 24; i++) begin
            s = HW'($urandom);
            key_for(s, ke, kd, kn);
            p = $urandom_range(int'(kn) + 2, 0);
            mis = ($urandom_range(3, 0) == 0);
            expect_of(s, p, 0, mis, 0, ep, ef, ee, es);
            apply(s, p, 0, mis, 0, 0, i[0], ep, ef, ee, es);
        end

        // go arriving in the FINISH cycle is dropped
        cur_seed = 16'h0003; cur_pt = 32'd5;
        @(negedge clk); seed_i = 16'h0003; plaintext_i = 32'd5; go = 1;
        @(negedge clk); go = 0;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk); #1;
            seen = done;
        end
        chk("finish_reached", 64'(seen), 64'd1);
        @(negedge clk); go = 1;
        @(posedge clk); #1;
        chk("finish_go_idle", 64'(busy), 64'd0);
        @(negedge clk); go = 0;
        @(posedge clk); #1;
        chk("finish_go_ignored", 64'({busy, core_start}), 64'd0);

        // reset in the middle of an encrypt wait
        cur_seed = 16'h0000; cur_pt = 32'd65;
        @(negedge clk); seed_i = 16'h0000; plaintext_i = 32'd65; go = 1;
        @(negedge clk); go = 0;
        seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk); #1;
            seen = (core_mode == 2'b10) && !core_start;
        end
        chk("enc_wait_reached", 64'(seen), 64'd1);
        @(negedge clk); rst = 0;
        #1;
        chk("midrun_reset_outputs", 64'(all_outs_or()), 64'd0);
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk("midrun_no_done", 64'(seen), 64'd0);
        @(negedge clk); rst = 1;
        apply(16'h0000, 32'd65, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
